// File: rtl/pc_gen_if.sv
`default_nettype none
//==============================================================================
// Module      : pc_gen_if
// Description : Execute-stage resolution bus between the execute stage and the
//               program-counter unit. The execute stage (master) presents the
//               instruction being resolved together with its ALU compare flags
//               and the prediction it was fetched under. The PC unit (slave)
//               answers combinationally with a redirect request and target.
// Signals     : ex_valid, ex_inst, ex_pc, ex_imm, ex_alu_out,
//               ex_zero, ex_slt, ex_sltu, ex_pred_taken   (master -> slave)
//               redirect, redirect_target                 (slave -> master)
// Revision    : 1.0 - initial release
//==============================================================================
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [31:0]     ex_inst;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_alu_out;
    logic            ex_zero;
    logic            ex_slt;
    logic            ex_sltu;
    logic            ex_pred_taken;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    modport master (
        output ex_valid, ex_inst, ex_pc, ex_imm, ex_alu_out,
               ex_zero, ex_slt, ex_sltu, ex_pred_taken,
        input  redirect, redirect_target
    );

    modport slave (
        input  ex_valid, ex_inst, ex_pc, ex_imm, ex_alu_out,
               ex_zero, ex_slt, ex_sltu, ex_pred_taken,
        output redirect, redirect_target
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
//==============================================================================
// Module      : pc_gen
// Description : Sequential program-counter unit. Holds the fetch PC and steps
//               it by 4, resolves RV32 branch/jal/jalr arriving from execute
//               and redirects fetch, predicts taken/not-taken for the current
//               fetch PC with a 2-bit-counter branch history table, traps on
//               misaligned redirect targets and keeps saturating branch and
//               mispredict counters.
// Ports       : clk, rst_n        clock / asynchronous active-low reset
//               stall             hold the fetch PC (redirects still apply)
//               ex                execute resolution bus (slave side)
//               pc, pred_taken    fetch PC and its BHT prediction
//               trap              one-cycle pulse after a misaligned redirect
//               branch_cnt        resolved conditional branches (saturating)
//               mispred_cnt       mispredicted conditional branches (saturating)
// Revision    : 1.0 - initial release
//==============================================================================
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              BHT_DEPTH    = 16,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    pc_gen_if.slave          ex,
    output logic [XLEN-1:0]  pc,
    output logic             pred_taken,
    output logic             trap,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int         c_idx_w     = $clog2(BHT_DEPTH);
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    // State
    logic [XLEN-1:0]  r_pc;
    logic             r_trap;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic [1:0]       r_bht [BHT_DEPTH];

    // Resolution
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [XLEN-1:0]  w_br_target;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_jalr_target;
    logic             w_is_branch;
    logic             w_br_taken;
    logic             w_need_redirect;
    logic [XLEN-1:0]  w_raw_target;
    logic             w_misaligned;
    logic             w_count;
    logic             w_mispred;
    logic [c_idx_w-1:0] w_fetch_idx;
    logic [c_idx_w-1:0] w_ex_idx;
    logic             w_unused;

    assign w_opcode      = ex.ex_inst[6:0];
    assign w_funct3      = ex.ex_inst[14:12];
    assign w_br_target   = ex.ex_pc + ex.ex_imm;
    assign w_seq_pc      = ex.ex_pc + XLEN'(4);
    assign w_jalr_target = {ex.ex_alu_out[XLEN-1:1], 1'b0};

    // Instruction bits outside opcode/funct3 and alu_out[0] are don't-care here.
    assign w_unused = &{1'b0, ex.ex_inst[31:15], ex.ex_inst[11:7], ex.ex_alu_out[0]};

    always_comb begin
        w_is_branch     = 1'b0;
        w_br_taken      = 1'b0;
        w_need_redirect = 1'b0;
        w_raw_target    = w_seq_pc;
        if (ex.ex_valid) begin
            case (w_opcode)
                c_op_branch: begin
                    w_is_branch = 1'b1;
                    case (w_funct3)
                        3'b000:  w_br_taken = ex.ex_zero;
                        3'b001:  w_br_taken = ~ex.ex_zero;
                        3'b100:  w_br_taken = ex.ex_slt;
                        3'b101:  w_br_taken = ~ex.ex_slt;
                        3'b110:  w_br_taken = ex.ex_sltu;
                        3'b111:  w_br_taken = ~ex.ex_sltu;
                        // 010/011 are not branches: ignored entirely
                        default: w_is_branch = 1'b0;
                    endcase
                    // Only a wrong prediction needs fetch corrected; the
                    // correct path is the target if taken, fall-through if not.
                    if (w_is_branch && (w_br_taken != ex.ex_pred_taken)) begin
                        w_need_redirect = 1'b1;
                        w_raw_target    = w_br_taken ? w_br_target : w_seq_pc;
                    end
                end
                c_op_jal: begin
                    w_need_redirect = 1'b1;
                    w_raw_target    = w_br_target;
                end
                c_op_jalr: begin
                    w_need_redirect = 1'b1;
                    w_raw_target    = w_jalr_target;
                end
                default: ;
            endcase
        end
    end

    assign w_misaligned = w_need_redirect & (|w_raw_target[1:0]);
    // A trapping branch leaves the predictor and statistics untouched.
    assign w_count      = w_is_branch & ~w_misaligned;
    assign w_mispred    = w_count & w_need_redirect;

    assign ex.redirect        = w_need_redirect;
    assign ex.redirect_target = w_misaligned ? TRAP_VECTOR : w_raw_target;

    assign w_fetch_idx = r_pc[c_idx_w+1:2];
    assign w_ex_idx    = ex.ex_pc[c_idx_w+1:2];

    // PC, trap pulse and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_trap        <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_trap <= w_misaligned;
            if (w_need_redirect) begin
                r_pc <= ex.redirect_target;
            end else if (!stall) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_count && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    // Branch history table: 2-bit saturating counters, MSB is the prediction.
    // Written at the edge, so a same-cycle read at the same index sees the
    // old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_count) begin
            if (w_br_taken) begin
                if (r_bht[w_ex_idx] != 2'b11) begin
                    r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
                end
            end else begin
                if (r_bht[w_ex_idx] != 2'b00) begin
                    r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
                end
            end
        end
    end

    assign pc          = r_pc;
    assign pred_taken  = r_bht[w_fetch_idx][1];
    assign trap        = r_trap;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
//==============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen. Directed sequences and a
//               vector table, then randomized traffic, all compared against a
//               behavioural model of fetch PC, predictor and counters.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pc_gen;

    localparam int          XLEN      = 32;
    localparam int          CNT_W     = 4;
    localparam int          BHT_DEPTH = 16;
    localparam logic [31:0] TRAPV     = 32'h0000_0100;
    localparam logic [6:0]  OP_BR     = 7'h63;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
    localparam logic [6:0]  OP_JALR   = 7'h67;
    localparam logic [6:0]  OP_ALU    = 7'h33;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic [31:0]      pc;
    logic             pred_taken;
    logic             trap;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    pc_gen_if #(.XLEN(XLEN)) ex_bus ();

    pc_gen #(
        .XLEN        (XLEN),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (TRAPV),
        .BHT_DEPTH   (BHT_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .ex         (ex_bus),
        .pc         (pc),
        .pred_taken (pred_taken),
        .trap       (trap),
        .branch_cnt (branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] ex_pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        zero;
        logic        slt;
        logic        sltu;
        logic        pred;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_red;
        logic [31:0] exp_tgt;
    } vec_t;

    typedef struct {
        logic        red;
        logic [31:0] tgt;
        logic        counted;
        logic        taken;
        logic        mis;
    } res_t;

    // Reference model state
    logic [31:0] m_pc;
    int          m_bht [BHT_DEPTH];
    int          m_bc;
    int          m_mc;
    logic        m_trap;

    int checks;
    int errors;

    function automatic stim_t mk(logic st, logic v, logic [6:0] op, logic [2:0] f3,
                                 logic [31:0] epc, logic [31:0] imm, logic [31:0] alu,
                                 logic z, logic lt, logic ltu, logic pr);
        stim_t s;
        s.stall = st;  s.valid = v;
        s.inst  = {17'b0, f3, 5'b0, op};
        s.ex_pc = epc; s.imm = imm; s.alu = alu;
        s.zero  = z;   s.slt = lt;  s.sltu = ltu; s.pred = pr;
        return s;
    endfunction

    function automatic stim_t idle(logic st);
        return mk(st, 1'b0, OP_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // What the execute-stage instruction means architecturally.
    function automatic res_t resolve(stim_t s);
        res_t        r;
        logic [6:0]  op;
        int          f3;
        r  = '{default: '0};
        op = s.inst[6:0];
        f3 = int'(s.inst[14:12]);
        if (!s.valid) return r;
        if (op == OP_JAL) begin
            r.red = 1'b1;
            r.tgt = s.ex_pc + s.imm;
        end else if (op == OP_JALR) begin
            r.red = 1'b1;
            r.tgt = s.alu & 32'hFFFF_FFFE;
        end else if (op == OP_BR && f3 != 2 && f3 != 3) begin
            case (f3)
                0:       r.taken = s.zero;
                1:       r.taken = !s.zero;
                4:       r.taken = s.slt;
                5:       r.taken = !s.slt;
                6:       r.taken = s.sltu;
                default: r.taken = !s.sltu;
            endcase
            r.counted = 1'b1;
            if (r.taken != s.pred) begin
                r.red = 1'b1;
                r.tgt = r.taken ? s.ex_pc + s.imm : s.ex_pc + 32'd4;
            end
        end
        if (r.red && (r.tgt % 4 != 0)) begin
            r.mis     = 1'b1;
            r.tgt     = TRAPV;
            r.counted = 1'b0;
        end
        return r;
    endfunction

    function automatic logic m_pred();
        return m_bht[int'((m_pc >> 2) % BHT_DEPTH)] >= 2;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_bc   = 0;
        m_mc   = 0;
        m_trap = 1'b0;
        for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
    endtask

    task automatic model_clock(stim_t s);
        res_t r;
        int   idx;
        r      = resolve(s);
        m_trap = r.mis;
        if (r.counted) begin
            idx = int'((s.ex_pc >> 2) % BHT_DEPTH);
            if (r.taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else         m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            m_bc = (m_bc == 2**CNT_W - 1) ? m_bc : m_bc + 1;
            if (r.red) m_mc = (m_mc == 2**CNT_W - 1) ? m_mc : m_mc + 1;
        end
        if (r.red)          m_pc = r.tgt;
        else if (!s.stall)  m_pc = m_pc + 32'd4;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(stim_t s);
        stall                = s.stall;
        ex_bus.ex_valid      = s.valid;
        ex_bus.ex_inst       = s.inst;
        ex_bus.ex_pc         = s.ex_pc;
        ex_bus.ex_imm        = s.imm;
        ex_bus.ex_alu_out    = s.alu;
        ex_bus.ex_zero       = s.zero;
        ex_bus.ex_slt        = s.slt;
        ex_bus.ex_sltu       = s.sltu;
        ex_bus.ex_pred_taken = s.pred;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(stim_t s);
        res_t r;
        drive(s);
        #2;
        r = resolve(s);
        chk("pc", pc, m_pc);
        chk("pred_taken", 32'(pred_taken), 32'(m_pred()));
        chk("redirect", 32'(ex_bus.redirect), 32'(r.red));
        if (r.red) chk("redirect_target", ex_bus.redirect_target, r.tgt);
        chk("trap", 32'(trap), 32'(m_trap));
        chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mc));
        @(posedge clk);
        #1;
        model_clock(s);
    endtask

    // Asynchronous reset in the middle of a cycle while a trapping jalr is
    // being resolved; the pending redirect and trap must be discarded.
    task automatic reset_mid();
        drive(mk(1'b0, 1'b1, OP_JALR, 3'd0, 32'h30, 32'h0, 32'h103, 1'b0, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_trap", 32'(trap), 32'h0);
        chk("rst_branch_cnt", 32'(branch_cnt), 32'h0);
        chk("rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
        chk("rst_pred_taken", 32'(pred_taken), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_pc", pc, 32'h0);
        chk("rst_hold_trap", 32'(trap), 32'h0);
        drive(idle(1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t  vt [15];
    stim_t s;

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        drive(idle(1'b0));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_trap", 32'(trap), 32'h0);
        chk("reset_branch_cnt", 32'(branch_cnt), 32'h0);
        chk("reset_mispred_cnt", 32'(mispred_cnt), 32'h0);
        rst_n = 1'b1;

        // Free-running fetch
        for (int i = 0; i < 4; i++) begin
            chk("idle_pc", pc, 32'(i * 4));
            step(idle(1'b0));
        end

        // beq taken, predicted not-taken: redirect to 0x60, entry 0 01->10
        s = mk(1'b0, 1'b1, OP_BR, 3'b000, 32'h40, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(s);
        chk("beq_pc", pc, 32'h60);
        chk("beq_bc", 32'(branch_cnt), 32'd1);
        chk("beq_mc", 32'(mispred_cnt), 32'd1);
        s.pred = 1'b1;
        step(s);
        chk("beq2_bc", 32'(branch_cnt), 32'd2);
        chk("beq2_mc", 32'(mispred_cnt), 32'd1);
        step(s);
        chk("beq3_bc", 32'(branch_cnt), 32'd3);

        // Entry 0 is saturated at 11: one not-taken leaves it predicting taken
        step(mk(1'b0, 1'b1, OP_JAL, 3'd0, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("bht_sat_pred", 32'(pred_taken), 32'd1);
        step(mk(1'b0, 1'b1, OP_BR, 3'b000, 32'h40, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("bht_nt_pc", pc, 32'h44);
        step(mk(1'b0, 1'b1, OP_JAL, 3'd0, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("bht_10_pred", 32'(pred_taken), 32'd1);
        step(mk(1'b0, 1'b1, OP_BR, 3'b000, 32'h40, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        step(mk(1'b0, 1'b1, OP_JAL, 3'd0, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("bht_01_pred", 32'(pred_taken), 32'd0);
        chk("bht_seq_bc", 32'(branch_cnt), 32'd5);
        chk("bht_seq_mc", 32'(mispred_cnt), 32'd3);

        // Misaligned jalr target: trap vector next cycle, trap pulse one cycle
        step(mk(1'b0, 1'b1, OP_JALR, 3'd0, 32'h50, 32'h0, 32'h103, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("trap_pc", pc, TRAPV);
        chk("trap_pulse", 32'(trap), 32'd1);
        chk("trap_bc", 32'(branch_cnt), 32'd5);
        step(idle(1'b0));
        chk("trap_clear", 32'(trap), 32'd0);

        // Redirect overrides stall; plain stall holds
        step(mk(1'b1, 1'b1, OP_JAL, 3'd0, 32'h10, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("stall_redirect_pc", pc, 32'h8);
        step(idle(1'b1));
        chk("stall_hold_pc1", pc, 32'h8);
        step(idle(1'b1));
        chk("stall_hold_pc2", pc, 32'h8);

        // Resolution vectors with hand-computed redirect/target
        vt[0]  = '{mk(0,1,OP_BR, 3'b001,32'h40,32'h20,0,1,0,0,0), 1'b0, 32'h0};
        vt[1]  = '{mk(0,1,OP_BR, 3'b001,32'h40,32'h20,0,1,0,0,1), 1'b1, 32'h44};
        vt[2]  = '{mk(0,1,OP_BR, 3'b100,32'h80,32'hFFFF_FFF0,0,0,1,0,0), 1'b1, 32'h70};
        vt[3]  = '{mk(0,1,OP_BR, 3'b101,32'h80,32'hFFFF_FFF0,0,0,1,0,1), 1'b1, 32'h84};
        vt[4]  = '{mk(0,1,OP_BR, 3'b110,32'h90,32'h10,0,0,0,0,1), 1'b1, 32'h94};
        vt[5]  = '{mk(0,1,OP_BR, 3'b111,32'h200,32'h8,0,0,0,0,0), 1'b1, 32'h208};
        vt[6]  = '{mk(0,1,OP_BR, 3'b010,32'h40,32'h20,0,1,1,1,0), 1'b0, 32'h0};
        vt[7]  = '{mk(0,1,OP_BR, 3'b011,32'h40,32'h20,0,0,0,0,1), 1'b0, 32'h0};
        vt[8]  = '{mk(0,0,OP_JAL,3'b000,32'h40,32'h20,0,0,0,0,0), 1'b0, 32'h0};
        vt[9]  = '{mk(0,1,OP_ALU,3'b000,32'h40,32'h20,0,1,0,0,0), 1'b0, 32'h0};
        vt[10] = '{mk(0,1,OP_JAL,3'b000,32'hFFFF_FFFC,32'h8,0,0,0,0,0), 1'b1, 32'h4};
        vt[11] = '{mk(0,1,OP_BR, 3'b000,32'h40,32'h22,0,1,0,0,0), 1'b1, TRAPV};
        vt[12] = '{mk(0,1,OP_JALR,3'b000,32'h40,32'h0,32'h2001,0,0,0,0), 1'b1, 32'h2000};
        vt[13] = '{mk(0,1,OP_BR, 3'b000,32'h42,32'h20,0,0,0,0,1), 1'b1, TRAPV};
        vt[14] = '{mk(0,1,OP_BR, 3'b111,32'h40,32'h20,0,0,0,1,0), 1'b0, 32'h0};
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].s);
            #1;
            chk("vec_redirect", 32'(ex_bus.redirect), 32'(vt[i].exp_red));
            if (vt[i].exp_red) chk("vec_target", ex_bus.redirect_target, vt[i].exp_tgt);
            step(vt[i].s);
        end

        // Counter saturation at CNT_W=4, then reset mid-operation
        reset_mid();
        for (int i = 0; i < 16; i++) begin
            step(mk(1'b0, 1'b1, OP_BR, 3'b000, 32'(32'h40 + i * 4), 32'h20, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0));
        end
        chk("sat_bc", 32'(branch_cnt), 32'hF);
        chk("sat_mc", 32'(mispred_cnt), 32'hF);
        step(mk(1'b0, 1'b1, OP_BR, 3'b000, 32'h40, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("sat_hold_bc", 32'(branch_cnt), 32'hF);
        chk("sat_hold_mc", 32'(mispred_cnt), 32'hF);
        reset_mid();
        // Every BHT entry back to weakly not-taken
        for (int i = 0; i < BHT_DEPTH; i++) begin
            chk("bht_reset_pred", 32'(pred_taken), 32'd0);
            step(idle(1'b0));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int         sel;
            if (n % 150 == 149) reset_mid();
            sel = int'($urandom_range(0, 9));
            f3  = 3'($urandom_range(0, 7));
            if (sel <= 5)      op = OP_BR;
            else if (sel == 6) op = OP_JAL;
            else if (sel == 7) op = OP_JALR;
            else               op = OP_ALU;
            s.stall = ($urandom_range(0, 3) == 0);
            s.valid = ($urandom_range(0, 4) != 0);
            s.inst  = {17'b0, f3, 5'b0, op};
            s.ex_pc = 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 7) == 0)  s.ex_pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) s.ex_pc = s.ex_pc | 32'h2;
            s.imm = 32'((int'($urandom_range(0, 63)) - 32) * 4);
            if ($urandom_range(0, 7) == 0)  s.imm = s.imm + 32'd2;
            s.alu = $urandom;
            if ($urandom_range(0, 3) != 0)  s.alu = s.alu & 32'hFFFF_FFFD;
            s.zero = 1'($urandom_range(0, 1));
            s.slt  = 1'($urandom_range(0, 1));
            s.sltu = 1'($urandom_range(0, 1));
            s.pred = 1'($urandom_range(0, 1));
            step(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
